// File: rtl/pulse_cmd_scheduler.sv
`timescale 1ns/1ps
// Pulse command scheduler: assembles 9-byte UART frames into clamped, shadowed generator config.
// Reply one cycle after the last byte; a trigger fires one cycle after its request or is held pending (depth 1) while gen_busy.
module pulse_cmd_scheduler #(
    parameter logic [7:0]  HDR_BYTE    = 8'h07,
    parameter logic [15:0] MIN_PULSE   = 16'd4,
    parameter logic [15:0] DEF_PULSE   = 16'd5,
    parameter int unsigned TIMEOUT_CYC = 104160,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    input  logic        key_en,
    input  logic        gen_busy,
    output logic [1:0]  pulse_select,
    output logic [15:0] pulse_width1,
    output logic [15:0] pulse_width2,
    output logic [15:0] pulse_gap,
    output logic        pulse_trig,
    output logic        cmd_pending,
    output logic [7:0]  tx_data,
    output logic        tx_flag,
    output logic        frame_err
);

    localparam int unsigned   TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {R_IDLE, R_COLLECT} rx_state_t;

    rx_state_t     state, state_nxt;
    logic [3:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [55:0]   shift_buf;
    logic          frame_end, tmo_hit;
    logic          frame_valid, frame_ok, req;
    logic [1:0]    stg_sel;
    logic [15:0]   stg_w1, stg_w2, stg_gap;

    function automatic logic [15:0] clamp(input logic [15:0] v);
        return (v < MIN_PULSE) ? MIN_PULSE : v;
    endfunction

    // shift_buf holds B1..B7 (B1 in the top byte); B8 is taken straight from rx_data.
    assign frame_valid = (shift_buf[55:49] == 7'd0) && (shift_buf[47:41] == 7'd0);
    assign req         = key_en | frame_ok;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= R_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            R_IDLE: begin
                if (rx_flag && rx_data == HDR_BYTE) state_nxt = R_COLLECT;
            end
            R_COLLECT: begin
                if (rx_flag) begin
                    if (byte_cnt == 4'd8) begin
                        frame_end = 1'b1;
                        state_nxt = R_IDLE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = R_IDLE;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            byte_cnt  <= 4'd0;
            tmo_cnt   <= '0;
            shift_buf <= '0;
            stg_sel   <= 2'b00;
            stg_w1    <= DEF_PULSE;
            stg_w2    <= DEF_PULSE;
            stg_gap   <= DEF_PULSE;
            frame_ok  <= 1'b0;
            tx_flag   <= 1'b0;
            tx_data   <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            tx_flag   <= 1'b0;
            frame_err <= 1'b0;
            if (state == R_IDLE) begin
                tmo_cnt  <= '0;
                byte_cnt <= (state_nxt == R_COLLECT) ? 4'd1 : 4'd0;
            end else if (rx_flag) begin
                shift_buf <= {shift_buf[47:0], rx_data};
                byte_cnt  <= byte_cnt + 4'd1;
                tmo_cnt   <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (frame_end) begin
                byte_cnt <= 4'd0;
                tx_flag  <= 1'b1;
                if (frame_valid) begin
                    tx_data  <= ACK_BYTE;
                    frame_ok <= 1'b1;
                    stg_sel  <= {shift_buf[40], shift_buf[48]};
                    stg_w1   <= clamp(shift_buf[39:24]);
                    stg_w2   <= clamp(shift_buf[23:8]);
                    stg_gap  <= clamp({shift_buf[7:0], rx_data});
                end else begin
                    tx_data   <= NAK_BYTE;
                    frame_err <= 1'b1;
                end
            end

            if (tmo_hit) begin
                byte_cnt  <= 4'd0;
                tmo_cnt   <= '0;
                tx_flag   <= 1'b1;
                tx_data   <= NAK_BYTE;
                frame_err <= 1'b1;
            end
        end
    end

    // A request landing in the trigger cycle is parked: the generator has not raised busy yet.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pulse_trig   <= 1'b0;
            cmd_pending  <= 1'b0;
            pulse_select <= 2'b00;
            pulse_width1 <= DEF_PULSE;
            pulse_width2 <= DEF_PULSE;
            pulse_gap    <= DEF_PULSE;
        end else begin
            pulse_trig <= 1'b0;
            if (pulse_trig) begin
                if (req) cmd_pending <= 1'b1;
            end else if ((req || cmd_pending) && !gen_busy) begin
                pulse_trig   <= 1'b1;
                cmd_pending  <= 1'b0;
                pulse_select <= stg_sel;
                pulse_width1 <= stg_w1;
                pulse_width2 <= stg_w2;
                pulse_gap    <= stg_gap;
            end else if (req) begin
                cmd_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_cmd_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for pulse_cmd_scheduler: directed scenarios plus random frames against a frame-level model.
module tb_pulse_cmd_scheduler;

    localparam int         TMO = 64;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_flag  = 1'b0;
    logic        key_en   = 1'b0;
    logic        gen_busy = 1'b0;
    logic [1:0]  pulse_select;
    logic [15:0] pulse_width1, pulse_width2, pulse_gap;
    logic        pulse_trig, cmd_pending;
    logic [7:0]  tx_data;
    logic        tx_flag, frame_err;

    always #5 sys_clk = ~sys_clk;

    pulse_cmd_scheduler #(.TIMEOUT_CYC(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_flag(rx_flag),
        .key_en(key_en), .gen_busy(gen_busy), .pulse_select(pulse_select),
        .pulse_width1(pulse_width1), .pulse_width2(pulse_width2), .pulse_gap(pulse_gap),
        .pulse_trig(pulse_trig), .cmd_pending(cmd_pending), .tx_data(tx_data),
        .tx_flag(tx_flag), .frame_err(frame_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int viol_cnt = 0;

    // Staged (m_*) and visible (o_*) config as the frame rules dictate.
    logic [1:0]  m_sel, o_sel;
    logic [15:0] m_w1, m_w2, m_gap, o_w1, o_w2, o_gap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Invariants watched every cycle: config moves only with pulse_trig; frame_err exactly on NAK replies.
    logic        rst_q = 1'b1;
    logic [49:0] prev_cfg;
    always @(posedge sys_clk) rst_q <= sys_rst;
    always @(negedge sys_clk) begin
        if (!rst_q) begin
            if ({pulse_select, pulse_width1, pulse_width2, pulse_gap} !== prev_cfg && !pulse_trig)
                viol_cnt++;
            if (frame_err !== (tx_flag && tx_data == NAK)) viol_cnt++;
        end
        prev_cfg = {pulse_select, pulse_width1, pulse_width2, pulse_gap};
    end

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] clampm(input logic [15:0] v);
        return (v < 16'd4) ? 16'd4 : v;
    endfunction

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_flag = 1'b1;
        tick();
        rx_flag = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [71:0] fr, input int n);
        for (int i = 0; i < n; i++)
            send_byte(fr[71 - 8*i -: 8], (i == 8) ? 0 : int'($urandom_range(0, 3)));
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_sel"}, 32'(pulse_select), 32'(o_sel));
        check({tag, "_w1"},  32'(pulse_width1), 32'(o_w1));
        check({tag, "_w2"},  32'(pulse_width2), 32'(o_w2));
        check({tag, "_gap"}, 32'(pulse_gap),    32'(o_gap));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_trig"}, 32'(pulse_trig), 0);
        check({tag, "_pend"}, 32'(cmd_pending), 0);
        check({tag, "_txf"},  32'(tx_flag), 0);
        check({tag, "_txd"},  32'(tx_data), 0);
        check({tag, "_ferr"}, 32'(frame_err), 0);
        check({tag, "_sel"},  32'(pulse_select), 0);
        check({tag, "_w1"},   32'(pulse_width1), 5);
        check({tag, "_w2"},   32'(pulse_width2), 5);
        check({tag, "_gap"},  32'(pulse_gap), 5);
    endtask

    task automatic model_reset();
        m_sel = 2'b00; m_w1 = 16'd5; m_w2 = 16'd5; m_gap = 16'd5;
        o_sel = m_sel; o_w1 = m_w1; o_w2 = m_w2; o_gap = m_gap;
    endtask

    // Returns whether the frame is valid and applies it to the staged model.
    function automatic logic model_frame(input logic [71:0] fr);
        logic [7:0] e1, e2;
        e1 = fr[63:56];
        e2 = fr[55:48];
        if (e1 > 8'd1 || e2 > 8'd1) return 1'b0;
        m_sel = {e2[0], e1[0]};
        m_w1  = clampm(fr[47:32]);
        m_w2  = clampm(fr[31:16]);
        m_gap = clampm(fr[15:0]);
        return 1'b1;
    endfunction

    // Full frame with gen_busy low: reply at N+1, trigger (or none) from N+2.
    task automatic do_frame(input logic [71:0] fr, input string tag);
        logic valid;
        logic seen;
        send_frame(fr, 9);
        valid = model_frame(fr);
        check({tag, "_txflag"}, 32'(tx_flag), 1);
        check({tag, "_txdata"}, 32'(tx_data), valid ? 32'(ACK) : 32'(NAK));
        check({tag, "_ferr"},   32'(frame_err), valid ? 0 : 1);
        tick();
        check({tag, "_onereply"}, 32'(tx_flag), 0);
        if (valid) begin
            check({tag, "_trig"}, 32'(pulse_trig), 1);
            o_sel = m_sel; o_w1 = m_w1; o_w2 = m_w2; o_gap = m_gap;
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (pulse_trig) seen = 1'b1;
                tick();
            end
            check({tag, "_notrig"}, 32'(seen), 0);
        end
        check_cfg(tag);
        tick();
    endtask

    function automatic logic [7:0] rnd_en();
        int r;
        r = int'($urandom_range(0, 9));
        return (r < 8) ? 8'(r % 2) : 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [15:0] rnd_w();
        return ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 6)) : 16'($urandom);
    endfunction

    initial begin
        int   waited;
        logic seen;
        model_reset();
        repeat (3) tick();
        sys_rst = 1'b0;
        check_reset("reset");

        // Basic frame with exact latencies.
        do_frame(72'h07_01_00_0020_0008_0010, "basic");

        // Clamp of width1 and gap.
        do_frame(72'h07_01_01_0002_0009_0000, "clamp");

        // Busy generator: frame and key merge into one pending trigger.
        gen_busy = 1'b1;
        send_frame(72'h07_00_01_0040_0050_0060, 9);
        void'(model_frame(72'h07_00_01_0040_0050_0060));
        check("busy_ack", 32'(tx_data), 32'(ACK));
        tick();
        check("busy_pend", 32'(cmd_pending), 1);
        key_en = 1'b1;
        tick();
        key_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (pulse_trig) seen = 1'b1;
            tick();
        end
        check("busy_notrig", 32'(seen), 0);
        check("busy_stillpend", 32'(cmd_pending), 1);
        check_cfg("busy_hold");
        gen_busy = 1'b0;
        tick();
        check("busy_fire", 32'(pulse_trig), 1);
        o_sel = m_sel; o_w1 = m_w1; o_w2 = m_w2; o_gap = m_gap;
        check_cfg("busy_cfg");
        tick();
        check("busy_pendclr", 32'(cmd_pending), 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (pulse_trig) seen = 1'b1;
            tick();
        end
        check("busy_single", 32'(seen), 0);

        // Inter-byte timeout.
        send_byte(8'h07, 0);
        send_byte(8'h01, 0);
        waited = 0;
        while (!tx_flag && waited < TMO + 20) begin
            tick();
            waited++;
        end
        check("tmo_window", 32'(waited >= TMO - 1 && waited <= TMO + 2), 1);
        check("tmo_nak", 32'(tx_data), 32'(NAK));
        check("tmo_ferr", 32'(frame_err), 1);
        tick();
        do_frame(72'h07_01_01_0100_0200_0300, "after_tmo");

        // Invalid enable byte, then a stray byte in idle.
        do_frame(72'h07_01_05_0020_0020_0020, "bad_en");
        send_byte(8'h33, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_flag || pulse_trig) seen = 1'b1;
            tick();
        end
        check("stray_silent", 32'(seen), 0);

        // Random frames and key triggers.
        for (int k = 0; k < 20; k++) begin
            do_frame({8'h07, rnd_en(), rnd_en(), rnd_w(), rnd_w(), rnd_w()}, $sformatf("rnd%0d", k));
            if ($urandom_range(0, 2) == 0) begin
                key_en = 1'b1;
                tick();
                key_en = 1'b0;
                check($sformatf("rndkey%0d_trig", k), 32'(pulse_trig), 1);
                o_sel = m_sel; o_w1 = m_w1; o_w2 = m_w2; o_gap = m_gap;
                check_cfg($sformatf("rndkey%0d", k));
                tick();
            end
        end

        // Reset mid-frame and mid-pending.
        gen_busy = 1'b1;
        key_en = 1'b1;
        tick();
        key_en = 1'b0;
        check("rst_pend_set", 32'(cmd_pending), 1);
        send_frame(72'h07_01_01_0030_0030_0030, 5);
        sys_rst = 1'b1;
        gen_busy = 1'b0;
        repeat (2) tick();
        sys_rst = 1'b0;
        model_reset();
        check_reset("midrst");
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pulse_trig || tx_flag) seen = 1'b1;
            tick();
        end
        check("midrst_quiet", 32'(seen), 0);
        key_en = 1'b1;
        tick();
        key_en = 1'b0;
        check("midrst_key_trig", 32'(pulse_trig), 1);
        check_cfg("midrst_key");
        repeat (3) tick();

        check("invariants", 32'(viol_cnt), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
